adc_serial_capture: RTL and testbench

Frame sequencer and deserializer for the external serial ADC, one stage downstream of the clock divider. The divided serial clock (`sclk`) drives the ADC SCLK pin and also enters this block as a same-domain registered signal. The block frames conversions with `cs_n`, shifts in `sdata` MSB-first on `sclk` rising edges, and presents each parallel sample with a valid/ready handshake. The frame repeats every `FRAME_LEN` sclk periods, which sets the sample rate: with the 50 MHz system clock and divide-by-18 sclk, the default of 69 gives about 40.26 kHz.

---
 rtl/adc_serial_capture_pkg.sv | 20 ++
 rtl/adc_serial_capture_if.sv | 31 +++
 rtl/adc_serial_capture_edge_rise.sv | 23 ++
 rtl/adc_serial_capture.sv | 153 +++++++++++++++
 tb/tb_adc_serial_capture.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_serial_capture_pkg.sv
// Shared definitions for the serial ADC capture path: frame states and the
// default sample-rate constants (sclk divider and frame length live together).
package adc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      QUIET
   } adc_state_e;

   // Divider terminal count for the upstream sclk generator.
   localparam int unsigned ADC_SCLK_DIV  = 8;
   // sclk periods per frame; with the divider above this sets ~40.26 kHz.
   localparam int unsigned ADC_FRAME_LEN = 69;
   // Leading zero bits clocked out by the ADC before the MSB.
   localparam int unsigned ADC_LEAD_BITS = 4;
   // Sample width.
   localparam int unsigned ADC_DATA_BITS = 12;

endpackage

// File: rtl/adc_serial_capture_if.sv
// Sample delivery bundle: parallel sample with valid/ready handshake plus the
// sticky overrun flag and its clear strobe.
interface adc_serial_capture_if
   import adc_pkg::*;
#(
   parameter int unsigned DATA_BITS = ADC_DATA_BITS
) ();

   logic [DATA_BITS-1:0] sample;
   logic                 sample_valid;
   logic                 sample_ready;
   logic                 overrun;
   logic                 overrun_clr;

   modport master (
      output sample,
      output sample_valid,
      output overrun,
      input  sample_ready,
      input  overrun_clr
   );

   modport slave (
      input  sample,
      input  sample_valid,
      input  overrun,
      output sample_ready,
      output overrun_clr
   );

endinterface

// File: rtl/adc_serial_capture_edge_rise.sv
// Registered rising-edge detector for a signal already synchronous to clock
// (e.g. the divided sclk). rise is high for the one clock where sig is newly 1.
module edge_rise (
   input  logic clock,
   input  logic reset_n,
   input  logic sig,
   output logic rise
);

   logic sig_d;

   // Delay the input by one clock for edge comparison.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sig_d <= 1'b0;
      end else begin
         sig_d <= sig;
      end
   end

   assign rise = sig & ~sig_d;

endmodule

// File: rtl/adc_serial_capture.sv
// Frame sequencer and deserializer for the external serial ADC. Frames are
// bracketed by cs_n, data is shifted MSB-first on sclk rising edges, and each
// completed sample is offered through a valid/ready handshake.
module adc_serial_capture
   import adc_pkg::*;
#(
   parameter int unsigned FRAME_LEN = ADC_FRAME_LEN,
   parameter int unsigned LEAD_BITS = ADC_LEAD_BITS,
   parameter int unsigned DATA_BITS = ADC_DATA_BITS
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 sclk,
   input  logic                 sdata,
   input  logic                 enable,
   output logic                 cs_n,
   adc_serial_capture_if.master smp
);

   localparam int unsigned            FCNT_W    = $clog2(FRAME_LEN);
   localparam logic [FCNT_W-1:0]      FIRST_BIT = FCNT_W'(LEAD_BITS);
   localparam logic [FCNT_W-1:0]      LAST_BIT  = FCNT_W'(LEAD_BITS + DATA_BITS - 1);
   localparam logic [FCNT_W-1:0]      FCNT_LAST = FCNT_W'(FRAME_LEN - 1);

   logic                 sclk_rise;
   adc_state_e           state, state_nxt;
   logic [FCNT_W-1:0]    fcnt, fcnt_nxt;
   logic                 cs_n_nxt;
   logic                 shift_en;
   logic                 load;
   // The shift register's top bit would be discarded on every shift, so only
   // DATA_BITS-1 bits are kept; the assembled word below is identical.
   logic [DATA_BITS-2:0] shreg;
   logic [DATA_BITS-1:0] shift_word;
   logic [DATA_BITS-1:0] sample_q;
   logic                 sample_valid_q;
   logic                 overrun_q;
   logic                 xfer;

   edge_rise u_sclk_rise (
      .clock   (clock),
      .reset_n (reset_n),
      .sig     (sclk),
      .rise    (sclk_rise)
   );

   assign shift_word = {shreg, sdata};
   assign xfer       = sample_valid_q & smp.sample_ready;

   // Frame state, frame counter and chip-select registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         fcnt  <= '0;
         cs_n  <= 1'b1;
      end else begin
         state <= state_nxt;
         fcnt  <= fcnt_nxt;
         cs_n  <= cs_n_nxt;
      end
   end

   // Next-state, counter and strobe decode; everything advances on sclk rise.
   always_comb begin
      state_nxt = state;
      fcnt_nxt  = fcnt;
      cs_n_nxt  = cs_n;
      shift_en  = 1'b0;
      load      = 1'b0;
      case (state)
         IDLE: begin
            fcnt_nxt = '0;
            cs_n_nxt = 1'b1;
            if (sclk_rise && enable) begin
               state_nxt = CONV;
               cs_n_nxt  = 1'b0;
            end
         end
         CONV: begin
            if (sclk_rise) begin
               fcnt_nxt = fcnt + FCNT_W'(1);
               if (fcnt >= FIRST_BIT && fcnt <= LAST_BIT) begin
                  shift_en = 1'b1;
               end
               if (fcnt == LAST_BIT) begin
                  load      = 1'b1;
                  cs_n_nxt  = 1'b1;
                  state_nxt = QUIET;
               end
            end
         end
         QUIET: begin
            if (sclk_rise) begin
               if (fcnt == FCNT_LAST) begin
                  fcnt_nxt = '0;
                  if (enable) begin
                     state_nxt = CONV;
                     cs_n_nxt  = 1'b0;
                  end else begin
                     state_nxt = IDLE;
                  end
               end else begin
                  fcnt_nxt = fcnt + FCNT_W'(1);
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            fcnt_nxt  = '0;
            cs_n_nxt  = 1'b1;
         end
      endcase
   end

   // Deserializer and output sample register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         shreg    <= '0;
         sample_q <= '0;
      end else begin
         if (shift_en) begin
            shreg <= shift_word[DATA_BITS-2:0];
         end
         if (load) begin
            sample_q <= shift_word;
         end
      end
   end

   // Handshake valid and sticky overrun; a load beats a same-cycle transfer or clear.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sample_valid_q <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         if (load) begin
            sample_valid_q <= 1'b1;
         end else if (xfer) begin
            sample_valid_q <= 1'b0;
         end
         if (load && sample_valid_q && !smp.sample_ready) begin
            overrun_q <= 1'b1;
         end else if (smp.overrun_clr) begin
            overrun_q <= 1'b0;
         end
      end
   end

   assign smp.sample       = sample_q;
   assign smp.sample_valid = sample_valid_q;
   assign smp.overrun      = overrun_q;

endmodule

// File: tb/tb_adc_serial_capture.sv
// Directed bench for adc_serial_capture: free-running sclk at 18 clocks per
// period, a behavioural ADC that shifts out lead zeros then a 12-bit word, and
// per-scenario tasks with hand-computed expectations.
module tb_adc_serial_capture;
   import adc_pkg::*;

   localparam int unsigned SCLK_PERIOD = 18;
   localparam int unsigned FRAME_CLKS  = ADC_FRAME_LEN * SCLK_PERIOD;               // 1242
   localparam int unsigned CS_LOW_CLKS = (ADC_LEAD_BITS + ADC_DATA_BITS) * SCLK_PERIOD; // 288

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   logic sclk    = 1'b0;
   logic sdata   = 1'b0;
   logic enable  = 1'b0;
   logic cs_n;

   adc_serial_capture_if #(.DATA_BITS(ADC_DATA_BITS)) smp ();

   adc_serial_capture #(
      .FRAME_LEN (ADC_FRAME_LEN),
      .LEAD_BITS (ADC_LEAD_BITS),
      .DATA_BITS (ADC_DATA_BITS)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .sclk    (sclk),
      .sdata   (sdata),
      .enable  (enable),
      .cs_n    (cs_n),
      .smp     (smp)
   );

   always #10 clock = ~clock;

   int          checks = 0;
   int          errors = 0;
   int unsigned cyc    = 0;

   always @(posedge clock) cyc++;

   // sclk generator: low for 9 clocks, high for 9, updated on falling clock edge.
   int unsigned sclk_cnt      = 0;
   int unsigned sclk_rise_cyc = 0;
   always @(negedge clock) begin
      sclk_cnt = (sclk_cnt == SCLK_PERIOD - 1) ? 0 : sclk_cnt + 1;
      if (sclk_cnt >= SCLK_PERIOD / 2) begin
         if (!sclk) sclk_rise_cyc = cyc;
         sclk = 1'b1;
      end else begin
         sclk = 1'b0;
      end
   end

   // ADC model: n counts sclk rises since cs_n fell; rise n carries lead zeros
   // for n<=4, then word bit [16-n] for n=5..16.
   logic [ADC_DATA_BITS-1:0] adc_word = '0;
   int                       adc_n    = 0;

   function automatic logic adc_bit(input int n, input logic [ADC_DATA_BITS-1:0] w);
      if (n >= int'(ADC_LEAD_BITS) + 1 && n <= int'(ADC_LEAD_BITS + ADC_DATA_BITS))
         return w[int'(ADC_LEAD_BITS + ADC_DATA_BITS) - n];
      return 1'b0;
   endfunction

   always @(negedge cs_n) adc_n = 0;
   always @(posedge sclk) if (cs_n === 1'b0) adc_n++;
   always @(negedge sclk) sdata = adc_bit(adc_n + 1, adc_word);

   // cs_n edge monitor (clock-cycle timestamps).
   logic        cs_prev       = 1'b1;
   int unsigned fall_cyc      = 0;
   int unsigned prev_fall_cyc = 0;
   int unsigned rise_cyc      = 0;
   int          fall_cnt      = 0;
   int          rise_cnt      = 0;
   always @(negedge clock) begin
      if (cs_prev === 1'b1 && cs_n === 1'b0) begin
         prev_fall_cyc = fall_cyc;
         fall_cyc      = cyc;
         fall_cnt++;
      end
      if (cs_prev === 1'b0 && cs_n === 1'b1) begin
         rise_cyc = cyc;
         rise_cnt++;
      end
      cs_prev = cs_n;
   end

   // ---------------- bounded waits ----------------
   task automatic wait_cs_fall(input int budget, input string name);
      int start;
      bit seen;
      start = fall_cnt;
      seen  = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clock); #1;
         if (fall_cnt != start) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s: cs_n fall got none within %0d clocks, want one", name, budget);
      end
   endtask

   task automatic wait_cs_rise(input int budget, input string name);
      int start;
      bit seen;
      start = rise_cnt;
      seen  = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clock); #1;
         if (rise_cnt != start) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s: cs_n rise got none within %0d clocks, want one", name, budget);
      end
   endtask

   task automatic wait_valid(input int budget, input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clock); #1;
         if (smp.sample_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s: sample_valid got 0 for %0d clocks, want 1", name, budget);
      end
   endtask

   task automatic wait_adc_n(input int n, input int budget, input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clock); #1;
         if (adc_n == n) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s: sclk rise count %0d never seen within %0d clocks", name, n, budget);
      end
   endtask

   task automatic release_reset_on_sclk_low();
      for (int i = 0; i < 40 && sclk !== 1'b0; i++) begin
         @(negedge clock); #1;
      end
      reset_n = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (3) @(negedge clock);
      #1;
      checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
      checks++; if (smp.sample !== 12'h000) begin errors++; $display("FAIL reset_sample: got %h want 000", smp.sample); end
      checks++; if (smp.sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", smp.sample_valid); end
      checks++; if (smp.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", smp.overrun); end
      release_reset_on_sclk_low();
      repeat (2) @(negedge clock);
   endtask

   task automatic test_basic();
      int unsigned en_cyc;
      adc_word = 12'hA5C;
      smp.sample_ready = 1'b1;
      enable = 1'b1;
      en_cyc = cyc;
      wait_cs_fall(40, "basic_first_fall");
      checks++;
      if (fall_cyc - sclk_rise_cyc != 1) begin
         errors++; $display("FAIL basic_fall_delay: got %0d clocks after sclk rise want 1", fall_cyc - sclk_rise_cyc);
      end
      checks++;
      if (fall_cyc - en_cyc > 20) begin
         errors++; $display("FAIL basic_first_frame: got %0d clocks after enable want <= 20", fall_cyc - en_cyc);
      end
      wait_valid(400, "basic_valid");
      checks++; if (smp.sample !== 12'hA5C) begin errors++; $display("FAIL basic_sample: got %h want a5c", smp.sample); end
      checks++;
      if (rise_cyc - fall_cyc != CS_LOW_CLKS) begin
         errors++; $display("FAIL basic_cs_low: got %0d clocks want %0d", rise_cyc - fall_cyc, CS_LOW_CLKS);
      end
      @(negedge clock); #1;
      checks++; if (smp.sample_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_width: got %b want 0 one clock later", smp.sample_valid); end
      wait_cs_fall(FRAME_CLKS + 10, "basic_second_fall");
      checks++;
      if (fall_cyc - prev_fall_cyc != FRAME_CLKS) begin
         errors++; $display("FAIL basic_frame_period: got %0d clocks want %0d", fall_cyc - prev_fall_cyc, FRAME_CLKS);
      end
   endtask

   task automatic test_reset_midframe();
      int unsigned rel_cyc;
      smp.sample_ready = 1'b0;
      wait_valid(400, "midrst_prior_valid");
      adc_word = 12'h36E;
      wait_cs_fall(FRAME_CLKS + 10, "midrst_frame_start");
      wait_adc_n(7, 200, "midrst_fcnt7");
      #3;
      reset_n = 1'b0;
      #1;
      checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL midrst_cs_n_async: got %b want 1", cs_n); end
      checks++; if (smp.sample !== 12'h000) begin errors++; $display("FAIL midrst_sample: got %h want 000", smp.sample); end
      checks++; if (smp.sample_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", smp.sample_valid); end
      checks++; if (smp.overrun !== 1'b0) begin errors++; $display("FAIL midrst_overrun: got %b want 0", smp.overrun); end
      repeat (3) @(negedge clock);
      #1;
      release_reset_on_sclk_low();
      rel_cyc = cyc;
      wait_cs_fall(40, "midrst_restart");
      checks++;
      if (fall_cyc - rel_cyc > 19) begin
         errors++; $display("FAIL midrst_restart_time: got %0d clocks after release want <= 19", fall_cyc - rel_cyc);
      end
      checks++;
      if (fall_cyc - sclk_rise_cyc != 1) begin
         errors++; $display("FAIL midrst_fall_delay: got %0d want 1", fall_cyc - sclk_rise_cyc);
      end
      wait_valid(400, "midrst_valid");
      checks++; if (smp.sample !== 12'h36E) begin errors++; $display("FAIL midrst_sample_after: got %h want 36e", smp.sample); end
      checks++;
      if (rise_cyc - fall_cyc != CS_LOW_CLKS) begin
         errors++; $display("FAIL midrst_cs_low: got %0d want %0d", rise_cyc - fall_cyc, CS_LOW_CLKS);
      end
   endtask

   task automatic test_overrun();
      smp.sample_ready = 1'b1;
      @(negedge clock); #1;
      smp.sample_ready = 1'b0;
      checks++; if (smp.sample_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain: got %b want 0", smp.sample_valid); end
      adc_word = 12'h123;
      wait_valid(FRAME_CLKS + 10, "ovr_first_load");
      checks++; if (smp.sample !== 12'h123) begin errors++; $display("FAIL ovr_sample1: got %h want 123", smp.sample); end
      checks++; if (smp.overrun !== 1'b0) begin errors++; $display("FAIL ovr_flag1: got %b want 0", smp.overrun); end
      adc_word = 12'hFFF;
      wait_cs_rise(FRAME_CLKS + 10, "ovr_second_load");
      checks++; if (smp.sample !== 12'hFFF) begin errors++; $display("FAIL ovr_sample2: got %h want fff", smp.sample); end
      checks++; if (smp.overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag2: got %b want 1", smp.overrun); end
      checks++; if (smp.sample_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid2: got %b want 1", smp.sample_valid); end
      smp.overrun_clr = 1'b1;
      @(negedge clock); #1;
      smp.overrun_clr = 1'b0;
      checks++; if (smp.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", smp.overrun); end
      checks++; if (smp.sample_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_kept: got %b want 1", smp.sample_valid); end
   endtask

   task automatic test_back_to_back();
      adc_word = 12'h3C7;
      wait_cs_fall(FRAME_CLKS + 10, "b2b_frame");
      wait_adc_n(15, 400, "b2b_bit15");
      @(posedge sclk);
      smp.sample_ready = 1'b1;
      @(negedge clock); #1;
      checks++; if (smp.sample_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", smp.sample_valid); end
      checks++; if (smp.sample !== 12'h3C7) begin errors++; $display("FAIL b2b_sample: got %h want 3c7", smp.sample); end
      checks++; if (smp.overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b want 0", smp.overrun); end
      @(negedge clock); #1;
      checks++; if (smp.sample_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b want 0", smp.sample_valid); end
   endtask

   task automatic test_enable_drop();
      int start;
      adc_word = 12'h5A3;
      wait_cs_fall(FRAME_CLKS + 10, "endrop_frame");
      wait_adc_n(5, 200, "endrop_fcnt5");
      enable = 1'b0;
      wait_valid(400, "endrop_valid");
      checks++; if (smp.sample !== 12'h5A3) begin errors++; $display("FAIL endrop_sample: got %h want 5a3", smp.sample); end
      @(negedge clock); #1;
      checks++; if (smp.sample_valid !== 1'b0) begin errors++; $display("FAIL endrop_delivered: got %b want 0", smp.sample_valid); end
      start = fall_cnt;
      repeat (3 * FRAME_CLKS) @(negedge clock);
      #1;
      checks++; if (fall_cnt != start) begin errors++; $display("FAIL endrop_no_frame: got %0d new cs_n falls want 0", fall_cnt - start); end
      checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL endrop_cs_n: got %b want 1", cs_n); end
   endtask

   task automatic test_clr_collision();
      smp.sample_ready = 1'b0;
      adc_word = 12'h0F0;
      enable = 1'b1;
      wait_valid(FRAME_CLKS + 40, "clr_first_load");
      checks++; if (smp.sample !== 12'h0F0) begin errors++; $display("FAIL clr_sample1: got %h want 0f0", smp.sample); end
      adc_word = 12'h70E;
      wait_cs_fall(FRAME_CLKS + 10, "clr_frame2");
      wait_adc_n(15, 400, "clr_bit15");
      @(posedge sclk);
      smp.overrun_clr = 1'b1;
      @(posedge clock); #1;
      smp.overrun_clr = 1'b0;
      @(negedge clock); #1;
      checks++; if (smp.overrun !== 1'b1) begin errors++; $display("FAIL clr_set_wins: got %b want 1", smp.overrun); end
      checks++; if (smp.sample !== 12'h70E) begin errors++; $display("FAIL clr_sample2: got %h want 70e", smp.sample); end
      enable = 1'b0;
   endtask

   initial begin
      smp.sample_ready = 1'b0;
      smp.overrun_clr  = 1'b0;
      test_reset();
      test_basic();
      test_reset_midframe();
      test_overrun();
      test_back_to_back();
      test_enable_drop();
      test_clr_collision();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
